// File: rtl/mp3_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mp3_pkg                                                          |
// | Shared constants and types for the MP3 front-panel key control.  |
// | Contents: volume level limits/width, volume FSM state encoding.  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package mp3_pkg;

  localparam int VOL_W = 4;
  localparam logic [VOL_W-1:0] VOL_MIN = 4'd0;  // loudest
  localparam logic [VOL_W-1:0] VOL_MAX = 4'd8;  // mute

  typedef enum logic [1:0] {
    VOL_IDLE        = 2'd0,
    VOL_WAIT_REPEAT = 2'd1,
    VOL_REPEATING   = 2'd2
  } vol_state_e;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_debounce                                                     |
// | 2-FF synchroniser, debounce counter, debounced level and a       |
// | one-cycle rise strobe for one raw push-button.                   |
// | Ports: clk, rst (async, active-high), key_i (raw key),           |
// |        level_o (debounced level), rise_o (press strobe).         |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_dly_q;
  logic             rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b00;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_i};
      level_dly_q <= level_q;
      // Rise is taken from the registered level so the strobe lands one
      // cycle after the flip; this fixes the DB_CYCLES+3 press latency.
      rise_q      <= level_q & ~level_dly_q;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule
`default_nettype wire

// File: rtl/mp3_key_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mp3_key_ctrl                                                     |
// | Front-panel key controller: debounced track strobes, saturating  |
// | 0..8 volume attenuation with auto-repeat, display highlights.    |
// | Inputs : clk, rst (async, active-high), i_btn_next, i_btn_pre,   |
// |          i_btn_up, i_btn_down (raw keys).                        |
// | Outputs: o_next, o_pre (track strobes), o_vol_plus, o_vol_dec    |
// |          (highlight flags), o_vol_level, o_vol_update (strobe).  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module mp3_key_ctrl
  import mp3_pkg::*;
#(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 20_000_000,
  parameter int VOL_INIT      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_btn_next,
  input  logic             i_btn_pre,
  input  logic             i_btn_up,
  input  logic             i_btn_down,
  output logic             o_next,
  output logic             o_pre,
  output logic             o_vol_plus,
  output logic             o_vol_dec,
  output logic [VOL_W-1:0] o_vol_level,
  output logic             o_vol_update
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  // Key index: 0 next, 1 pre, 2 up, 3 down.
  logic [3:0] raw_w;
  logic [3:0] level_w;
  logic [3:0] rise_w;
  logic [1:0] step_w;          // 0 up step, 1 down step
  logic       unused_level_w;  // track keys only need their press strobe

  assign raw_w          = {i_btn_down, i_btn_up, i_btn_pre, i_btn_next};
  assign unused_level_w = ^level_w[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk    (clk),
        .rst    (rst),
        .key_i  (raw_w[gi]),
        .level_o(level_w[gi]),
        .rise_o (rise_w[gi])
      );
    end

    // One repeat FSM per volume key; held is the debounced level.
    for (gi = 0; gi < 2; gi++) begin : g_vol_fsm
      vol_state_e       state_q;
      logic [RPT_W-1:0] cnt_q;
      logic             held_w;
      logic             press_w;

      assign held_w  = level_w[gi + 2];
      assign press_w = rise_w[gi + 2];
      assign step_w[gi] = ((state_q == VOL_IDLE)        && press_w) ||
                          ((state_q == VOL_WAIT_REPEAT) && held_w && (cnt_q == DELAY_LAST)) ||
                          ((state_q == VOL_REPEATING)   && held_w && (cnt_q == PERIOD_LAST));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= VOL_IDLE;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            VOL_IDLE: begin
              cnt_q <= '0;
              if (press_w) state_q <= VOL_WAIT_REPEAT;
            end
            VOL_WAIT_REPEAT: begin
              if (!held_w) begin
                state_q <= VOL_IDLE;
                cnt_q   <= '0;
              end else if (cnt_q == DELAY_LAST) begin
                state_q <= VOL_REPEATING;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            VOL_REPEATING: begin
              if (!held_w) begin
                state_q <= VOL_IDLE;
                cnt_q   <= '0;
              end else if (cnt_q == PERIOD_LAST) begin
                cnt_q <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            default: begin
              state_q <= VOL_IDLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  logic [VOL_W-1:0]  level_q, level_d;
  logic              vol_update_q, vol_update_d;
  logic              vol_plus_q, vol_dec_q;
  logic [HOLD_W-1:0] hold_q;
  logic              next_q, pre_q;

  // Up wins over down; a step at a limit leaves the level and strobe alone.
  always_comb begin
    level_d      = level_q;
    vol_update_d = 1'b0;
    if (step_w[0]) begin
      if (level_q != VOL_MIN) begin
        level_d      = level_q - VOL_W'(1);
        vol_update_d = 1'b1;
      end
    end else if (step_w[1]) begin
      if (level_q != VOL_MAX) begin
        level_d      = level_q + VOL_W'(1);
        vol_update_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q      <= VOL_W'(VOL_INIT);
      vol_update_q <= 1'b0;
      vol_plus_q   <= 1'b0;
      vol_dec_q    <= 1'b0;
      hold_q       <= '0;
      next_q       <= 1'b0;
      pre_q        <= 1'b0;
    end else begin
      next_q       <= rise_w[0];
      pre_q        <= rise_w[1] & ~rise_w[0];
      level_q      <= level_d;
      vol_update_q <= vol_update_d;
      // Any step, saturated or not, re-arms the highlight.
      if (step_w[0]) begin
        vol_plus_q <= 1'b1;
        vol_dec_q  <= 1'b0;
        hold_q     <= HOLD_W'(HOLD_CYCLES);
      end else if (step_w[1]) begin
        vol_plus_q <= 1'b0;
        vol_dec_q  <= 1'b1;
        hold_q     <= HOLD_W'(HOLD_CYCLES);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
        if (hold_q == HOLD_W'(1)) begin
          vol_plus_q <= 1'b0;
          vol_dec_q  <= 1'b0;
        end
      end
    end
  end

  assign o_next       = next_q;
  assign o_pre        = pre_q;
  assign o_vol_plus   = vol_plus_q;
  assign o_vol_dec    = vol_dec_q;
  assign o_vol_level  = level_q;
  assign o_vol_update = vol_update_q;

endmodule
`default_nettype wire
